// File: rtl/mul_pkg.sv
// Shared op encodings, FSM state codes and magnitude helper for mul_seq.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    localparam int MUL_MAX_W = 64;

    typedef logic [1:0] mul_state_t;

    localparam mul_state_t ST_IDLE = 2'd0;
    localparam mul_state_t ST_RUN  = 2'd1;
    localparam mul_state_t ST_FIX  = 2'd2;
    localparam mul_state_t ST_DONE = 2'd3;

    // Two's-complement magnitude; callers truncate to their own width,
    // which maps the most negative value onto its unsigned magnitude.
    function automatic logic [MUL_MAX_W-1:0] abs_n(
        input logic [MUL_MAX_W-1:0] v,
        input logic                 neg
    );
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2^BPC accumulation step of the iterative multiplier.
module mul_step #(
    parameter int N   = 32,
    parameter int BPC = 4,
    parameter int CW  = 3
) (
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   mcand,
    input  logic [BPC-1:0] bits,
    input  logic [CW-1:0]  count,
    output logic [2*N-1:0] acc_next
);

    logic [N+BPC-1:0] pp;
    logic [31:0]      shamt;

    assign pp       = {{BPC{1'b0}}, mcand} * {{N{1'b0}}, bits};
    assign shamt    = 32'(count) * 32'(BPC);
    assign acc_next = acc + ((2*N)'(pp) << shamt);

endmodule

// File: rtl/mul_seq.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), BPC bits per cycle.
// Define MUL_ZERO_BYPASS_EN to skip RUN when either operand is zero.
module mul_seq
    import mul_pkg::*;
#(
    parameter int N   = 32,
    parameter int BPC = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] multiplicand,
    input  logic [N-1:0] multiplier,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int STEPS = N / BPC;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if ((N % BPC) != 0 || N > MUL_MAX_W) begin : g_bad_cfg
        $error("mul_seq: N must be a multiple of BPC and at most 64");
    end

    mul_state_t     state;
    logic [1:0]     op_q;
    logic           neg_q;
    logic [N-1:0]   mcand_q;
    logic [N-1:0]   mplier_q;
    logic [2*N-1:0] acc_q;
    logic [CW-1:0]  count_q;
    logic [N-1:0]   result_q;

    logic           sa, sb, accept, zero_op, last;
    logic [N-1:0]   mcand_mag, mplier_mag;
    logic [2*N-1:0] acc_step, prod;

    assign sa = multiplicand[N-1]
              & (op == MUL_OP_MULH || op == MUL_OP_MULHSU);
    assign sb = multiplier[N-1] & (op == MUL_OP_MULH);

    assign mcand_mag  = N'(abs_n(MUL_MAX_W'(multiplicand), sa));
    assign mplier_mag = N'(abs_n(MUL_MAX_W'(multiplier), sb));

    assign accept = start && (state == ST_IDLE || state == ST_DONE);
    assign last   = (count_q == CW'(STEPS - 1));
    assign prod   = neg_q ? -acc_q : acc_q;

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    mul_step #(
        .N   (N),
        .BPC (BPC),
        .CW  (CW)
    ) u_step (
        .acc      (acc_step_in()),
        .mcand    (mcand_q),
        .bits     (mplier_q[BPC-1:0]),
        .count    (count_q),
        .acc_next (acc_step)
    );

    function automatic logic [2*N-1:0] acc_step_in();
        return acc_q;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= MUL_OP_MUL;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    acc_q    <= acc_step;
                    mplier_q <= mplier_q >> BPC;
                    count_q  <= count_q + 1'b1;
                    if (last) state <= ST_FIX;
                end
                ST_FIX: begin
                    result_q <= (op_q == MUL_OP_MUL) ? prod[N-1:0]
                                                     : prod[2*N-1:N];
                    state    <= ST_DONE;
                end
                default: begin
                    if (accept) begin
                        op_q     <= op;
                        neg_q    <= sa ^ sb;
                        mcand_q  <= mcand_mag;
                        mplier_q <= mplier_mag;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state    <= zero_op ? ST_FIX : ST_RUN;
                    end else begin
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy   = (state == ST_RUN) || (state == ST_FIX);
    assign done   = (state == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// Randomised self-checking bench for mul_seq against a 64-bit arithmetic model.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        busy, done;
    logic [31:0] result;

    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_seq #(.N(32), .BPC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .result       (result)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (o)
            2'b01:   p = 64'(sa * sb);
            2'b10:   p = 64'(sa * ub);
            default: p = 64'(a) * 64'(b);
        endcase
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_BYPASS_EN
        if (a == 0 || b == 0) return 2;
`endif
        return 10;
    endfunction

    // Wait for done after an accept edge; returns the cycle index and busy count.
    task automatic wait_done(output int cyc, output int busy_cnt);
        bit seen = 0;
        cyc = 0;
        busy_cnt = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1;
            else if (busy) busy_cnt++;
        end
        if (!seen) check("done_timeout", 64'(cyc), 64'(0));
    endtask

    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int cyc, bc, lat;
        lat = exp_lat(a, b);
        @(negedge clk);
        start = 1'b1; op = o; multiplicand = a; multiplier = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        multiplicand = $urandom;
        multiplier = $urandom;
        wait_done(cyc, bc);
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_busy"}, 64'(bc), 64'(lat - 1));
        check({tag, "_res"}, 64'(result), 64'(exp));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'(0));
        check({tag, "_hold"}, 64'(result), 64'(exp));
    endtask

    initial begin
        int cyc, bc, dcnt;
        logic [1:0]  o;
        logic [31:0] a, b;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_result", 64'(result), 64'(0));

        do_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A);
        do_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        do_op("mul_min", 2'b00, 32'h80000000, 32'h80000000, 32'h00000000);
        do_op("mulhu_ones", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        do_op("mulhsu_ones", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_op("mulh_ones", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        do_op("mul_zero", 2'b00, 32'h0, 32'h1234, 32'h0);

        // Restart while busy must be ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b00; multiplicand = 32'd3; multiplier = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b11; multiplicand = 32'd100; multiplier = 32'd9;
        @(negedge clk);
        start = 1'b0;
        cyc = 4;
        dcnt = 0;
        while (dcnt == 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) dcnt++;
        end
        check("ign_lat", 64'(cyc), 64'(10));
        check("ign_res", 64'(result), 64'(15));
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("ign_single_done", 64'(dcnt), 64'(1));

        // Reset in the middle of a MULHU.
        @(negedge clk);
        start = 1'b1; op = 2'b11; multiplicand = 32'hDEADBEEF; multiplier = 32'h12345678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_result", 64'(result), 64'(0));
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("mid_rst_no_done", 64'(dcnt), 64'(0));
        do_op("post_rst", 2'b11, 32'hDEADBEEF, 32'h12345678,
              ref_mul(2'b11, 32'hDEADBEEF, 32'h12345678));

        // Back-to-back: start held, second op accepted in the DONE cycle.
        @(negedge clk);
        start = 1'b1; op = 2'b01; multiplicand = 32'hFFFFFF00; multiplier = 32'd77;
        @(posedge clk);
        #1;
        op = 2'b10; multiplicand = 32'h87654321; multiplier = 32'hF0F0F0F0;
        wait_done(cyc, bc);
        check("b2b_lat1", 64'(cyc), 64'(10));
        check("b2b_res1", 64'(result), 64'(ref_mul(2'b01, 32'hFFFFFF00, 32'd77)));
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc, bc);
        check("b2b_lat2", 64'(cyc), 64'(10));
        check("b2b_res2", 64'(result),
              64'(ref_mul(2'b10, 32'h87654321, 32'hF0F0F0F0)));

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h0;
                1: b = 32'h0;
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            do_op("rand", o, a, b, ref_mul(o, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
